// File: rtl/div.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done
// handshake, registered quotient/remainder and a divide-by-zero flag.
module div #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             done,
    output logic             dbz
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t           state_q, state_d;
    // The partial remainder is always below y between iterations, so its
    // extra top bit is only needed inside the trial subtraction.
    logic [WIDTH-1:0] ac_q, ac_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        shifted    = {ac_q, qr_q[WIDTH-1]};
        trial      = shifted - {1'b0, y_q};

        state_d    = state_q;
        ac_d       = ac_q;
        qr_d       = qr_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        dbz_pend_d = 1'b0;
        q_d        = q_q;
        r_d        = r_q;

        // A divide-by-zero completes one edge after acceptance; a start taken
        // on that same edge is applied afterwards and so takes precedence.
        if (dbz_pend_q) begin
            dbz_d  = 1'b1;
            q_d    = '0;
            r_d    = '0;
            done_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (y == '0) begin
                        dbz_pend_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        dbz_d   = 1'b0;
                        ac_d    = '0;
                        qr_d    = x;
                        y_d     = y;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    ac_d = trial[WIDTH-1:0];
                    qr_d = {qr_q[WIDTH-2:0], 1'b1};
                end else begin
                    ac_d = shifted[WIDTH-1:0];
                    qr_d = {qr_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    q_d     = qr_d;
                    r_d     = ac_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ac_q       <= '0;
            qr_q       <= '0;
            y_q        <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            dbz_pend_q <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
        end else begin
            state_q    <= state_d;
            ac_q       <= ac_d;
            qr_q       <= qr_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            dbz_pend_q <= dbz_pend_d;
            q_q        <= q_d;
            r_q        <= r_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;
    assign q    = q_q;
    assign r    = r_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div (WIDTH=4): directed vector table, divide-by-zero,
// busy-start rejection, back-to-back, abort by reset and an exhaustive sweep.
module tb_div;

    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edbz;
    } vec_t;

    typedef struct {
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edbz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         done;
    logic         dbz;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_starts = 0;
    int n_dones  = 0;
    exp_t sb[$];

    div #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .x    (x),
        .y    (y),
        .busy (busy),
        .q    (q),
        .r    (r),
        .done (done),
        .dbz  (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_dones++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("q", {28'd0, q}, {28'd0, e.eq});
                chk("r", {28'd0, r}, {28'd0, e.er});
                chk("dbz", {31'd0, dbz}, {31'd0, e.edbz});
            end
        end
    end

    task automatic run_op(input logic [W-1:0] xi, input logic [W-1:0] yi,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        int lat;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        x     = xi;
        y     = yi;
        e.eq = eq; e.er = er; e.edbz = edbz;
        sb.push_back(e);
        n_starts++;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (yi != '0) chk("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, (yi == '0) ? 32'd1 : W);
    endtask

    vec_t dir[10];
    int   lat;
    int   dones_before;

    initial begin
        dir[0] = '{4'd1,  4'd1,  4'd1, 4'd0, 1'b0};
        dir[1] = '{4'd2,  4'd2,  4'd1, 4'd0, 1'b0};
        dir[2] = '{4'd2,  4'd1,  4'd2, 4'd0, 1'b0};
        dir[3] = '{4'd0,  4'd2,  4'd0, 4'd0, 1'b0};
        dir[4] = '{4'd3,  4'd2,  4'd1, 4'd1, 1'b0};
        dir[5] = '{4'd15, 4'd5,  4'd3, 4'd0, 1'b0};
        dir[6] = '{4'd15, 4'd2,  4'd7, 4'd1, 1'b0};
        dir[7] = '{4'd1,  4'd15, 4'd0, 4'd1, 1'b0};
        dir[8] = '{4'd2,  4'd4,  4'd0, 4'd2, 1'b0};
        dir[9] = '{4'd13, 4'd7,  4'd1, 4'd6, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dbz", {31'd0, dbz}, 32'd0);
        chk("rst_q", {28'd0, q}, 32'd0);
        chk("rst_r", {28'd0, r}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd7, 4'd2, 4'd3, 4'd1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_q", {28'd0, q}, 32'd3);
        chk("hold_r", {28'd0, r}, 32'd1);
        chk("hold_dbz", {31'd0, dbz}, 32'd0);
        chk("hold_done", {31'd0, done}, 32'd0);

        for (int i = 0; i < 10; i++)
            run_op(dir[i].x, dir[i].y, dir[i].eq, dir[i].er, dir[i].edbz);

        run_op(4'd2, 4'd0, 4'd0, 4'd0, 1'b1);
        run_op(4'd3, 4'd2, 4'd1, 4'd1, 1'b0);

        // 15/5 with start re-asserted and operands changed mid-calculation.
        @(negedge clk);
        start = 1'b1; x = 4'd15; y = 4'd5;
        sb.push_back('{4'd3, 4'd0, 1'b0});
        n_starts++;
        @(negedge clk);
        x = 4'd1; y = 4'd1;
        chk("calc_q_held", {28'd0, q}, 32'd1);
        chk("calc_r_held", {28'd0, r}, 32'd1);
        repeat (2) @(negedge clk);
        start = 1'b0; x = 4'd9; y = 4'd0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("ignored_start_done_seen", {31'd0, done}, 32'd1);
        start = 1'b1; x = 4'd13; y = 4'd7;
        sb.push_back('{4'd1, 4'd6, 1'b0});
        n_starts++;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_latency", lat, W);

        // Abort 7/2 by reset mid-calculation.
        @(negedge clk);
        start = 1'b1; x = 4'd7; y = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        dones_before = n_dones;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_dbz", {31'd0, dbz}, 32'd0);
        chk("abort_q", {28'd0, q}, 32'd0);
        chk("abort_r", {28'd0, r}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_done", n_dones, dones_before);

        for (int xi = 0; xi < 16; xi++) begin
            for (int yi = 0; yi < 16; yi++) begin
                logic [W-1:0] xv, yv;
                xv = W'(xi);
                yv = W'(yi);
                if (yi == 0) run_op(xv, yv, '0, '0, 1'b1);
                else         run_op(xv, yv, W'(xi / yi), W'(xi % yi), 1'b0);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("one_done_per_start", n_dones, n_starts);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
